// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: shifts by up to STEP positions per clock behind valid/ready handshakes.
// Define SEQ_SHIFT_ROTATE_EN to build the ROR path; without it op 11 behaves as SRL.
module seq_shift_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amount,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_carry
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSra = 2'b10;
`ifdef SEQ_SHIFT_ROTATE_EN
  localparam logic [1:0] OpRor = 2'b11;
`endif

  // One extra bit so a per-cycle step equal to WIDTH is representable.
  localparam int unsigned KW = AW + 1;
  localparam logic [KW-1:0] StepK  = KW'(STEP);
  localparam logic [KW-1:0] WidthK = KW'(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0]    rem_q;
  logic [1:0]       op_q;
  logic             carry_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_carry_q;
  logic             out_valid_q;

  logic [KW-1:0]           k;
  logic [AW-1:0]           rem_next;
  logic [WIDTH-1:0]        step_data;
  logic                    step_carry;
  logic [WIDTH-1:0]        left_pre;
  logic [WIDTH-1:0]        right_pre;
  logic signed [WIDTH-1:0] sra_src;

  always_comb begin
    k          = ({1'b0, rem_q} < StepK) ? {1'b0, rem_q} : StepK;
    rem_next   = rem_q - k[AW-1:0];
    sra_src    = data_q;
    // Value shifted by k-1: its edge bit is the last one to leave the word.
    left_pre   = data_q << (k - 1'b1);
    right_pre  = data_q >> (k - 1'b1);
    step_data  = data_q >> k;
    step_carry = right_pre[0];
    case (op_q)
      OpSll: begin
        step_data  = data_q << k;
        step_carry = left_pre[WIDTH-1];
      end
      OpSra: begin
        step_data  = WIDTH'(sra_src >>> k);
        step_carry = right_pre[0];
      end
`ifdef SEQ_SHIFT_ROTATE_EN
      OpRor: begin
        step_data  = (data_q >> k) | (data_q << (WidthK - k));
        step_carry = right_pre[0];
      end
`endif
      default: begin
        step_data  = data_q >> k;
        step_carry = right_pre[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      rem_q       <= '0;
      op_q        <= 2'b00;
      carry_q     <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q  <= in_data;
            rem_q   <= in_amount;
            op_q    <= in_op;
            carry_q <= 1'b0;
            state_q <= (in_amount == '0) ? StDone : StShift;
          end
        end
        StShift: begin
          data_q  <= step_data;
          carry_q <= step_carry;
          rem_q   <= rem_next;
          if (rem_next == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          // First DONE cycle publishes the result into the output registers.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= data_q;
            out_carry_q <= carry_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_zero  = ~|out_data_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: three instances (STEP 1, 4, 2) driven with directed vectors.
module tb_seq_shift_unit;

  localparam int NDut = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NDut-1:0]  in_valid;
  logic [NDut-1:0]  in_ready;
  logic [15:0]      in_data   [NDut];
  logic [3:0]       in_amount [NDut];
  logic [1:0]       in_op     [NDut];
  logic [NDut-1:0]  out_valid;
  logic [NDut-1:0]  out_ready;
  logic [15:0]      out_data  [NDut];
  logic [NDut-1:0]  out_zero;
  logic [NDut-1:0]  out_carry;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int          dut;
    logic [15:0] data;
    logic        carry;
    logic        zero;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  logic [NDut-1:0] prev_valid = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    seq_shift_unit #(
      .WIDTH(16),
      .STEP (g == 0 ? 1 : (g == 1 ? 4 : 2))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_amount(in_amount[g]),
      .in_op    (in_op[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .out_zero (out_zero[g]),
      .out_carry(out_carry[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on the rising out_valid, payload on the result handshake.
  always @(negedge clk) begin
    for (int d = 0; d < NDut; d++) begin
      if (out_valid[d] && !prev_valid[d]) begin
        if (exp_q.size() == 0) check("unexpected_valid", 32'(d), 32'hFFFF_FFFF);
        else begin
          check("dut_order", 32'(d), 32'(exp_q[0].dut));
          check("latency", 32'(cyc), 32'(exp_q[0].due));
        end
      end
      if (out_valid[d] && out_ready[d] && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", 32'(out_data[d]), 32'(e.data));
        check("out_carry", 32'(out_carry[d]), 32'(e.carry));
        check("out_zero", 32'(out_zero[d]), 32'(e.zero));
      end
      prev_valid[d] <= out_valid[d];
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int d, input logic [1:0] op, input logic [15:0] data,
                       input logic [3:0] amt, input logic [15:0] ed, input logic ec,
                       input int lat);
    logic rdy;
    bit   done = 0;
    in_valid[d]  = 1'b1;
    in_op[d]     = op;
    in_data[d]   = data;
    in_amount[d] = amt;
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = in_ready[d];
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_q.push_back('{dut: d, data: ed, carry: ec, zero: (ed == 16'h0), due: cyc + lat});
        done = 1;
      end
    end
    in_valid[d] = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    for (int d = 0; d < NDut; d++) begin
      in_data[d]   = '0;
      in_amount[d] = '0;
      in_op[d]     = '0;
    end
    #2;
    for (int d = 0; d < NDut; d++) begin
      check("rst_in_ready", 32'(in_ready[d]), 32'd1);
      check("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check("rst_out_data", 32'(out_data[d]), 32'd0);
      check("rst_out_zero", 32'(out_zero[d]), 32'd1);
      check("rst_out_carry", 32'(out_carry[d]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // STEP=1
    issue(0, 2'b00, 16'h8001, 4'd1, 16'h0002, 1'b1, 2);
    wait_idle();
    issue(0, 2'b00, 16'h0003, 4'd15, 16'h8000, 1'b1, 16);
    wait_idle();
    issue(0, 2'b11, 16'h1234, 4'd0, 16'h1234, 1'b0, 1);
    wait_idle();
    // STEP=4
    issue(1, 2'b10, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 5);
    wait_idle();
    issue(1, 2'b01, 16'h8000, 4'd15, 16'h0001, 1'b0, 5);
    wait_idle();
    issue(1, 2'b01, 16'h0001, 4'd1, 16'h0000, 1'b1, 2);
    wait_idle();
    issue(1, 2'b00, 16'h0F0F, 4'd5, 16'hE1E0, 1'b1, 3);
    wait_idle();
    issue(1, 2'b10, 16'h1234, 4'd0, 16'h1234, 1'b0, 1);
    wait_idle();
`ifdef SEQ_SHIFT_ROTATE_EN
    issue(1, 2'b11, 16'h1234, 4'd4, 16'h4123, 1'b0, 2);
    wait_idle();
    issue(2, 2'b11, 16'h0001, 4'd4, 16'h1000, 1'b0, 3);
    wait_idle();
`else
    issue(1, 2'b11, 16'h1234, 4'd4, 16'h0123, 1'b0, 2);
    wait_idle();
    issue(2, 2'b11, 16'h0001, 4'd4, 16'h0000, 1'b0, 3);
    wait_idle();
`endif

    // Backpressure: result held in DONE, second request waits until after completion.
    out_ready[0] = 1'b0;
    issue(0, 2'b00, 16'h0003, 4'd2, 16'h000C, 1'b0, 3);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid[0]) got = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("bp_valid_rise", 32'(got), 32'd1);
    in_valid[0]  = 1'b1;
    in_op[0]     = 2'b01;
    in_data[0]   = 16'h00F0;
    in_amount[0] = 4'd4;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid[0]), 32'd1);
      check("bp_out_data", 32'(out_data[0]), 32'h000C);
      check("bp_out_carry", 32'(out_carry[0]), 32'd0);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after", 32'(in_ready[0]), 32'd1);
    check("bp_valid_after", 32'(out_valid[0]), 32'd0);
    exp_q.push_back('{dut: 0, data: 16'h000F, carry: 1'b0, zero: 1'b0, due: cyc + 1 + 5});
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    check("bp_second_accepted", 32'(in_ready[0]), 32'd0);
    wait_idle();

    // Asynchronous reset in the middle of a STEP=1 SRL by 10.
    in_valid[0]  = 1'b1;
    in_op[0]     = 2'b01;
    in_data[0]   = 16'h8000;
    in_amount[0] = 4'd10;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    check("mid_in_ready", 32'(in_ready[0]), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("mid_rst_out_data", 32'(out_data[0]), 32'd0);
    check("mid_rst_out_zero", 32'(out_zero[0]), 32'd1);
    check("mid_rst_out_carry", 32'(out_carry[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 2'b00, 16'h0001, 4'd1, 16'h0002, 1'b0, 2);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
